// File: rtl/fp_mul_arbiter_if.sv
// Bundles the requester handshakes and the shared multiplier start/done
// signals of fp_mul_arbiter. The arbiter connects through the slave
// modport. The environment (requesters plus multiplier) connects through
// the master modport.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
);
    // requester side
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_result;
    logic                  resp_overflow;
    logic [REQ_W-1:0]      resp_id;

    // shared multiplier side
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_start;
    logic [31:0]           mul_result;
    logic                  mul_overflow;
    logic                  mul_done;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        input  mul_result, mul_overflow, mul_done,
        output req_ready, resp_valid, resp_result, resp_overflow, resp_id,
        output mul_a, mul_b, mul_start
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        output mul_result, mul_overflow, mul_done,
        input  req_ready, resp_valid, resp_result, resp_overflow, resp_id,
        input  mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier between
// NUM_REQ requesters. Each operation runs IDLE -> ISSUE -> WAIT -> RESP.
// A watchdog in WAIT substitutes NAN_VAL when the multiplier never answers.
// The timeout_err flag is sticky and is cleared only by reset.
module fp_mul_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          REQ_W   = 2,
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
    input  logic                clk,
    input  logic                rst,
    fp_mul_arbiter_if.slave     bus,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   ptr_q, ptr_d;
    logic [REQ_W-1:0]   id_q, id_d;
    logic [31:0]        mul_a_q, mul_a_d;
    logic [31:0]        mul_b_q, mul_b_d;
    logic [31:0]        res_q, res_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;

    logic               found;
    logic [REQ_W-1:0]   win;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] resp_valid_c;
    logic               mul_start_c;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = REQ_W'(idx);
            end
        end
    end

    // Next-state and output decode of the operation sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        req_ready_c = '0;
        mul_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c[win] = 1'b1;
                    mul_a_d          = bus.req_a[32*int'(win) +: 32];
                    mul_b_d          = bus.req_b[32*int'(win) +: 32];
                    id_d             = win;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_c = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    res_d   = bus.mul_result;
                    ovf_d   = bus.mul_overflow;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Multiplier never answered: release the requester with a NaN.
                    res_d   = NAN_VAL;
                    ovf_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // Only the owner's accept matters; the owner drops to lowest priority.
                if (bus.resp_ready[id_q]) begin
                    ptr_d   = id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-hot response valid for the owner while the result is held.
    always_comb begin
        resp_valid_c = '0;
        if (state_q == RESP) begin
            resp_valid_c[id_q] = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= REQ_W'(NUM_REQ - 1);
            id_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Grants are suppressed while reset is asserted so no requester sees an
    // acceptance that the sequencer will not act on.
    assign bus.req_ready     = req_ready_c & {NUM_REQ{rst}};
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_result   = res_q;
    assign bus.resp_overflow = ovf_q;
    assign bus.resp_id       = id_q;
    assign bus.mul_a         = mul_a_q;
    assign bus.mul_b         = mul_b_q;
    assign bus.mul_start     = mul_start_c;
    assign busy              = (state_q != IDLE);
    assign timeout_err       = terr_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed requester traffic, a behavioural
// multiplier with programmable done latency, and a cycle-level transaction
// model that predicts every arbiter output.
module tb_fp_mul_arbiter;

    localparam int          N   = 4;
    localparam int          W   = 2;
    localparam int          TO  = 16;
    localparam logic [31:0] NAN = 32'h7FC00000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic terr;

    fp_mul_arbiter_if #(.NUM_REQ(N), .REQ_W(W)) bus ();

    fp_mul_arbiter #(
        .NUM_REQ(N), .REQ_W(W), .TIMEOUT(TO), .NAN_VAL(NAN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (terr)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_s = 1'b0;
    int   cfg_lat = 2;   // multiplier done latency after start; 0 = never

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Known IEEE-754 products; anything else maps to a distinctive pattern.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {1'b0, 32'h40000000};
            64'h41200000_C1A00000: return {1'b0, 32'hC3480000};
            64'h40400000_40800000: return {1'b0, 32'h41400000};
            64'h40000000_40000000: return {1'b0, 32'h40800000};
            64'h3F000000_40800000: return {1'b0, 32'h40000000};
            64'h7F7FFFFF_40000000: return {1'b1, 32'h7F800000};
            default:               return {1'b0, a ^ b};
        endcase
    endfunction

    // Behavioural multiplier: done exactly cfg_lat cycles after start.
    initial begin
        int          done_at;
        logic [31:0] op_a, op_b;
        logic [32:0] p;
        done_at          = -1;
        op_a             = '0;
        op_b             = '0;
        bus.mul_done     = 1'b0;
        bus.mul_result   = 32'hDEADBEEF;
        bus.mul_overflow = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (cyc == done_at) begin
                p                = fmul(op_a, op_b);
                bus.mul_done     = 1'b1;
                bus.mul_result   = p[31:0];
                bus.mul_overflow = p[32];
            end else begin
                bus.mul_done     = 1'b0;
                bus.mul_result   = 32'hDEADBEEF;
                bus.mul_overflow = 1'b1;
            end
            if (bus.mul_start === 1'b1) begin
                done_at = (cfg_lat == 0) ? -1 : cyc + cfg_lat;
                op_a    = bus.mul_a;
                op_b    = bus.mul_b;
            end
        end
    end

    // Transaction model and per-cycle comparison.
    bit          m_act  = 1'b0;
    int          m_id   = 0;
    int          m_grant = 0;
    int          m_resp = 0;
    int          m_last = N - 1;
    logic [31:0] m_a, m_b, m_res;
    logic        m_ovf  = 1'b0;
    logic        m_to   = 1'b0;
    logic        m_terr = 1'b0;
    int          rv_first = -1;

    int          n_resp = 0;
    int          n_start = 0;
    int          last_lat = 0;
    int          last_id = 0;
    logic [31:0] last_res = '0;
    logic        last_ovf = 1'b0;
    logic [N-1:0] last_rv = '0;
    int          gq[$];

    always @(negedge clk) begin
        logic [N-1:0] e_rr, e_rv;
        logic [32:0]  p;
        int           w, s;
        if (!rst_s) begin
            m_act  = 1'b0;
            m_last = N - 1;
            m_terr = 1'b0;
        end
        if (m_act && m_to && cyc == m_resp) m_terr = 1'b1;

        e_rr = '0;
        w    = -1;
        if (!m_act && rst === 1'b1) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && bus.req_valid[(m_last + k) % N]) w = (m_last + k) % N;
            end
            if (w >= 0) e_rr[w] = 1'b1;
        end
        e_rv = (m_act && cyc >= m_resp) ? (N'(1) << m_id) : '0;

        chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
        chk("mul_start", 32'(bus.mul_start), 32'(m_act && cyc == m_grant + 1));
        chk("busy", 32'(busy), 32'(m_act));
        chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
        chk("timeout_err", 32'(terr), 32'(m_terr));
        if (m_act) begin
            chk("resp_id", 32'(bus.resp_id), 32'(m_id));
            if (cyc < m_resp) begin
                chk("mul_a", bus.mul_a, m_a);
                chk("mul_b", bus.mul_b, m_b);
            end
            if (e_rv != '0) begin
                chk("resp_result", bus.resp_result, m_res);
                chk("resp_overflow", 32'(bus.resp_overflow), 32'(m_ovf));
            end
        end

        if (bus.mul_start === 1'b1) n_start++;
        for (int k = 0; k < N; k++) if (bus.req_ready[k] === 1'b1) gq.push_back(k);
        if (m_act && bus.resp_valid != '0 && rv_first < 0) rv_first = cyc;

        if (e_rv != '0 && bus.resp_ready[m_id]) begin
            n_resp++;
            last_res = bus.resp_result;
            last_ovf = bus.resp_overflow;
            last_id  = int'(bus.resp_id);
            last_rv  = bus.resp_valid;
            last_lat = rv_first - m_grant;
            m_act    = 1'b0;
            m_last   = m_id;
        end

        if (e_rr != '0) begin
            m_act    = 1'b1;
            m_id     = w;
            m_a      = bus.req_a[32*w +: 32];
            m_b      = bus.req_b[32*w +: 32];
            m_grant  = cyc;
            rv_first = -1;
            s        = cyc + 1;
            if (cfg_lat >= 1 && cfg_lat <= TO) begin
                p      = fmul(m_a, m_b);
                m_resp = s + cfg_lat + 1;
                m_res  = p[31:0];
                m_ovf  = p[32];
                m_to   = 1'b0;
            end else begin
                m_resp = s + TO + 1;
                m_res  = NAN;
                m_ovf  = 1'b0;
                m_to   = 1'b1;
            end
        end
    end

    task automatic drv_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int id, input int bound, input string nm);
        int i;
        i = 0;
        smp();
        while (bus.req_ready[id] !== 1'b1 && i < bound) begin
            smp();
            i++;
        end
        if (bus.req_ready[id] !== 1'b1) expire({nm, "_grant"});
    endtask

    task automatic wait_nresp(input int tgt, input int bound, input string nm);
        int i;
        i = 0;
        while (n_resp < tgt && i < bound) begin
            smp();
            i++;
        end
        if (n_resp < tgt) expire({nm, "_resp"});
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
    endtask

    task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string nm);
        int tgt;
        cfg_lat = lat;
        drv_edge();
        set_ops(id, a, b);
        bus.req_valid[id] = 1'b1;
        tgt = n_resp + 1;
        wait_grant(id, 20, nm);
        drv_edge();
        bus.req_valid[id] = 1'b0;
        wait_nresp(tgt, 60, nm);
    endtask

    initial begin
        int tgt, s0, i;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '1;
        rst            = 1'b0;

        // Reset state after two edges with rst low
        drv_edge();
        drv_edge();
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_mul_start", 32'(bus.mul_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_terr", 32'(terr), 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_mul_b", bus.mul_b, 0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_ovf", 32'(bus.resp_overflow), 0);
        chk("rst_id", 32'(bus.resp_id), 0);
        rst = 1'b1;

        // Single requester, done two cycles after start
        s0 = n_start;
        single(0, 32'h3F800000, 32'h40000000, 2, "single");
        chk("single_res", last_res, 32'h40000000);
        chk("single_ovf", 32'(last_ovf), 0);
        chk("single_id", last_id, 0);
        chk("single_rv", 32'(last_rv), 32'h1);
        chk("single_lat", last_lat, 4);
        chk("single_starts", n_start - s0, 1);

        // All four requesters continuously valid, from fresh reset
        drv_edge();
        rst = 1'b0;
        drv_edge();
        drv_edge();
        rst = 1'b1;
        cfg_lat = 2;
        set_ops(0, 32'h41200000, 32'hC1A00000);
        set_ops(1, 32'h40400000, 32'h40800000);
        set_ops(2, 32'h40000000, 32'h40000000);
        set_ops(3, 32'h3F000000, 32'h40800000);
        gq.delete();
        tgt = n_resp + 5;
        bus.req_valid = '1;
        wait_nresp(tgt, 200, "rr");
        drv_edge();
        bus.req_valid = '0;
        chk("rr_count", gq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) chk($sformatf("rr_grant%0d", k), gq[k], exp_ord[k]);
        end
        chk("rr_last_res", last_res, 32'hC3480000);
        chk("rr_last_id", last_id, 0);

        // Overflow propagation at minimum latency
        single(2, 32'h7F7FFFFF, 32'h40000000, 1, "ovf");
        chk("ovf_res", last_res, 32'h7F800000);
        chk("ovf_flag", 32'(last_ovf), 1);
        chk("ovf_lat", last_lat, 3);

        // Backpressure on requester 1 with requester 0 waiting
        cfg_lat = 2;
        bus.resp_ready = 4'b1101;
        drv_edge();
        set_ops(1, 32'h40400000, 32'h40800000);
        set_ops(0, 32'h3F800000, 32'h40000000);
        bus.req_valid[1] = 1'b1;
        tgt = n_resp + 2;
        wait_grant(1, 20, "bp");
        drv_edge();
        bus.req_valid = 4'b0001;
        i = 0;
        smp();
        while (bus.resp_valid[1] !== 1'b1 && i < 40) begin
            smp();
            i++;
        end
        if (bus.resp_valid[1] !== 1'b1) expire("bp_rv");
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv", 32'(bus.resp_valid), 32'h2);
            chk("bp_res", bus.resp_result, 32'h41400000);
            chk("bp_rr", 32'(bus.req_ready), 0);
            smp();
        end
        drv_edge();
        bus.resp_ready = '1;
        smp();
        smp();
        chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
        drv_edge();
        bus.req_valid = '0;
        wait_nresp(tgt, 60, "bp");
        chk("bp_last_res", last_res, 32'h40000000);
        chk("bp_last_id", last_id, 0);

        // Watchdog: multiplier never completes
        single(3, 32'h40000000, 32'h40000000, 0, "wd");
        chk("wd_res", last_res, NAN);
        chk("wd_ovf", 32'(last_ovf), 0);
        chk("wd_lat", last_lat, TO + 2);
        chk("wd_terr", 32'(terr), 1);
        single(0, 32'h3F800000, 32'h40000000, 2, "after_wd");
        chk("after_wd_res", last_res, 32'h40000000);
        chk("after_wd_terr", 32'(terr), 1);

        // Reset during WAIT, late done, then requester 0 priority
        cfg_lat = 10;
        tgt = n_resp;
        drv_edge();
        set_ops(1, 32'h40400000, 32'h40800000);
        bus.req_valid[1] = 1'b1;
        wait_grant(1, 20, "mid");
        drv_edge();
        bus.req_valid = '0;
        drv_edge();
        rst = 1'b0;
        drv_edge();
        rst = 1'b1;
        smp();
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rv", 32'(bus.resp_valid), 0);
        repeat (15) smp();
        chk("mid_no_resp", n_resp, tgt);
        chk("mid_busy_late", 32'(busy), 0);
        cfg_lat = 2;
        drv_edge();
        set_ops(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b0011;
        tgt = n_resp + 2;
        smp();
        chk("mid_prio", 32'(bus.req_ready), 32'h1);
        drv_edge();
        bus.req_valid[0] = 1'b0;
        wait_grant(1, 20, "mid2");
        drv_edge();
        bus.req_valid = '0;
        wait_nresp(tgt, 60, "mid2");
        chk("mid2_res", last_res, 32'h41400000);
        chk("mid2_id", last_id, 1);

        repeat (3) smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin arbiter that shares one single-precision floating-point multiplier between NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the multiplier's start/done protocol. It returns the result and overflow flag to the requester that owns the operation. It sits between the requesting datapath blocks and the floating_point_mt instance, and includes a watchdog so that a missing done cannot hang the shared resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ))
TIMEOUT, 16, maximum cycles spent in WAIT before the operation is aborted
NAN_VAL, 32'h7FC00000, result returned on timeout

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  NUM_REQ  per-requester operand valid
req_a  in  NUM_REQ*32  operand A; requester i at bits [32i+31:32i]
req_b  in  NUM_REQ*32  operand B; same packing as req_a
req_ready  out  NUM_REQ  one-hot pulse; operands of that requester accepted this cycle
resp_valid  out  NUM_REQ  one-hot; result is pending for that requester
resp_ready  in  NUM_REQ  per-requester response accept
resp_result  out  32  product, valid while any resp_valid bit is high
resp_overflow  out  1  overflow flag accompanying resp_result
resp_id  out  REQ_W  index of the current owner
mul_a  out  32  multiplier operand A
mul_b  out  32  multiplier operand B
mul_start  out  1  multiplier start, one-cycle pulse
mul_result  in  32  multiplier result
mul_overflow  in  1  multiplier overflow flag
mul_done  in  1  multiplier completion
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; set on the first watchdog abort, cleared only by reset

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE; pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready, resp_valid, mul_start, busy and timeout_err = 0.
  - mul_a, mul_b, resp_result = 0; resp_overflow = 0; resp_id = 0.
  - Reset in any state aborts the operation in flight with no response. The multiplier's own reset is driven separately at top level.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first asserted req_valid, searching upward from pointer+1 with wrap modulo NUM_REQ.
  - If a winner exists: req_ready[winner]=1 for this cycle only; latch req_a/req_b of the winner into mul_a/mul_b; resp_id = winner; go to ISSUE.
  - If no request: req_ready stays 0; remain in IDLE.
- ISSUE: mul_start=1 for exactly one cycle; mul_a/mul_b held stable; watchdog counter cleared; go to WAIT.
- WAIT:
  - mul_start=0; mul_a/mul_b stay stable until the operation leaves WAIT.
  - If mul_done=1: capture mul_result and mul_overflow into resp_result/resp_overflow; go to RESP.
  - Else if counter == TIMEOUT-1: resp_result = NAN_VAL, resp_overflow = 0, timeout_err = 1; go to RESP.
  - Else: counter increments.
  - Minimum latency from the req_ready pulse to resp_valid is 3 cycles, reached when mul_done arrives in the first WAIT cycle.
- RESP:
  - resp_valid[resp_id]=1; resp_result, resp_overflow and resp_id held stable.
  - When resp_ready[resp_id]=1: pointer = resp_id; go to IDLE.
  - resp_ready bits of other requesters are ignored.
- mul_done is ignored outside WAIT.
- req_valid may drop without penalty while the requester is not being granted.
- A requester whose response is still pending may assert req_valid again. It is not arbitrated until the arbiter returns to IDLE, and then only in its round-robin turn. The requester just served has the lowest priority in the next arbitration.
- Only one operation is in flight at a time; there is no pipelining across requesters.
- The result is passed through unchanged: zero, NaN and infinity semantics belong to the multiplier.

Test Plan:
- Single requester: rst low for 2 cycles, then req0 with a=3F800000, b=40000000; multiplier model returns done 2 cycles after start -> mul_start pulses once; resp_valid=0001, resp_result=40000000, overflow 0, resp_id=0.
- All four requesters valid continuously, resp_ready always high -> grant order 0,1,2,3,0. The last grant carries requester 0's operands, 41200000 x C1A00000 -> C3480000.
- Overflow propagation: 7F7FFFFF x 40000000; model returns 7F800000 with overflow 1 -> resp_result=7F800000, resp_overflow=1.
- Backpressure: hold resp_ready[1] low for 5 cycles -> resp_valid[1] and resp_result stable. No req_ready pulses during that time even with req0 valid. After resp_ready, req0 is granted next cycle.
- Watchdog: model never asserts done -> after exactly TIMEOUT=16 WAIT cycles resp_result=7FC00000, timeout_err=1. timeout_err is still 1 after a later successful operation.
- Reset mid-WAIT: assert rst=0 during WAIT -> next cycle busy=0 and resp_valid=0. A late mul_done is ignored. The next request is served starting with requester 0 priority.
